lsu_ctrl: RTL and testbench
===========================

# lsu_ctrl

Load/store sequencer sitting between the execute stage and the data-memory bus. It takes the memory-type decode produced for each instruction: type, read/write, access width and signedness. It runs one req/ack bus transaction per memory instruction, generates byte enables, aligns store data and extends load data. It stalls the pipeline for the duration of the access and aborts hung transactions with a timeout.

## Interface
Parameters:
- XLEN, 32, data/address width.
- TIMEOUT, 16, maximum number of BUSY cycles without ack before the access is aborted (≥1).

Ports:
- clk  in  1  clock; all registers update on the rising edge.
- rst_n  in  1  reset; asynchronous and active-low.
- ex_valid_i  in  1  execute-stage instruction valid.
- ex_mtype_i  in  1  1 = memory instruction.
- ex_mem_rw_i  in  1  1 = load, 0 = store.
- ex_mem_width_i  in  2  0 = byte, 1 = half, 2 = word, 3 = treated as word.
- ex_mem_rdtype_i  in  1  load extension: 0 = sign-extend, 1 = zero-extend.
- ex_addr_i  in  XLEN  effective address (ALU result).
- ex_wdata_i  in  XLEN  store data, rs2.
- stall_o  out  1  hold the execute stage.
- bus_req_o  out  1  bus request.
- bus_we_o  out  1  1 = write.
- bus_addr_o  out  XLEN  word-aligned address {addr[XLEN-1:2],2'b00}.
- bus_be_o  out  4  byte enables.
- bus_wdata_o  out  XLEN  lane-replicated store data.
- bus_ack_i  in  1  transaction complete; rdata valid in the same cycle.
- bus_rdata_i  in  XLEN  read word.
- wb_valid_o  out  1  load result valid, 1-cycle pulse.
- wb_data_o  out  XLEN  extended load result.
- err_o  out  1  1-cycle pulse: timeout or misalignment.
- misalign_o  out  1  1-cycle pulse: misaligned access. Tied to 0 without LSU_MISALIGN_CHK_EN.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE:
  - An op is accepted when ex_valid_i & ex_mtype_i.
  - On accept: latch rw, width, rdtype, addr[1:0], word address, and the lane-aligned wdata and be, then go to BUSY.
  - The misalignment exception path is described under Configuration.
- BUSY:
  - bus_req_o = 1; we, addr, be and wdata are held stable from the latched values.
  - Inputs are ignored.
  - On bus_ack_i, capture the extended load data and go to DONE.
  - The timeout counter increments each BUSY cycle without ack. When the counter reaches TIMEOUT, drop req and go to DONE with the error flag set.
  - ack takes priority over timeout when both occur in the same cycle.
- DONE:
  - Lasts one cycle.
  - wb_valid_o = 1 only for a load that completed without error.
  - err_o = 1 if the access was aborted.
  - No new op is accepted in DONE; the next state is always IDLE.
- Byte enables:
  - Byte: be = 4'b0001 << addr[1:0].
  - Half: be = 4'b0011 << {addr[1],1'b0}.
  - Word: be = 4'b1111.
- wdata lane replication:
  - Byte: {4{wdata[7:0]}}.
  - Half: {2{wdata[15:0]}}.
  - Word: wdata unchanged.
- Load extraction:
  - Select the byte or half lane indexed by addr[1:0] or addr[1].
  - Extend to XLEN by sign (rdtype = 0) or by zero (rdtype = 1).
  - For words, rdtype is ignored.
- stall_o = (state==IDLE & accept) | (state==BUSY). stall_o is 0 in DONE, so the pipeline advances at the end of the DONE cycle.
- Non-memory instructions are never stalled.

## Timing
- Accept in cycle T; bus_req_o is high from T+1.
- Zero-wait ack at T+1 gives DONE/wb_valid_o at T+2. Minimum latency is 2 cycles; stall_o is high at T and T+1.
- An ack arriving in cycle T+k gives DONE at T+k+1.
- Timeout: with no ack, bus_req_o is high for exactly TIMEOUT cycles, then err_o pulses in the following cycle.
- wb_data_o is registered and holds its last value outside DONE.
- bus_ack_i outside BUSY is ignored.
- Reset values, all 0: state = IDLE, stall_o, bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o, wb_valid_o, wb_data_o, err_o, misalign_o, timeout counter.
- Reset asserted mid-transaction drops bus_req_o immediately (asynchronously). The access is abandoned and no pulse is produced.

## Configuration
- LSU_MISALIGN_CHK_EN defined:
  - In IDLE, a half with addr[0] = 1, or a word (width 2 or 3) with addr[1:0] ≠ 0, is accepted with no bus transaction.
  - The block goes IDLE→DONE; misalign_o = err_o = 1 in DONE, and wb_valid_o = 0.
  - stall_o is high only in the accept cycle.
- LSU_MISALIGN_CHK_EN undefined:
  - Offending low address bits are forced to zero: addr[0] for halves, addr[1:0] for words.
  - The access proceeds normally; misalign_o is constant 0.

## Structure
- The shared package holds:
  - state encoding (IDLE/BUSY/DONE);
  - width codes (MEM_B = 0, MEM_H = 1, MEM_W = 2);
  - rw codes (MEM_LOAD = 1, MEM_STORE = 0).
- One sub-module, lsu_align: purely combinational. It does be/wdata generation from width and addr[1:0], and load lane extraction and extension from the rdata word.
- The FSM and the timeout counter live in lsu_ctrl.

## Test plan
- LB at addr 0x103, zero-wait ack, rdata 0x80FF_FF00 -> bus_be_o = 4'b1000, bus_addr_o = 0x100, DONE at T+2, wb_data_o = 0xFFFF_FF80.
- LHU at addr 0x202, ack after 3 wait cycles, rdata 0x8001_1234 -> be = 4'b1100, wb_data_o = 0x0000_8001, stall_o high for 5 cycles.
- SB at 0x001, wdata 0x0000_00AB -> bus_we_o = 1, be = 4'b0010, bus_wdata_o = 0xABAB_ABAB, wb_valid_o = 0 in DONE.
- SW with no ack, TIMEOUT = 16 -> bus_req_o high 16 cycles, err_o pulse, wb_valid_o = 0, next op accepted normally.
- LW at 0x102 -> with LSU_MISALIGN_CHK_EN: no bus_req_o, misalign_o = err_o = 1 at T+1. Without it: bus_addr_o = 0x100, be = 4'b1111.
- rst_n low during BUSY -> bus_req_o and stall_o go to 0 immediately. After release the state is IDLE and a following LW completes normally.

Source files
------------

// File: rtl/lsu_ctrl_pkg.sv
// lsu_ctrl_pkg: shared definitions for the load/store sequencer.
//   state_t       FSM encoding (IDLE/BUSY/DONE)
//   MEM_B/H/W     access width codes (3 is treated as word)
//   MEM_LOAD/STORE read/write codes
//   is_misaligned helper used when LSU_MISALIGN_CHK_EN is defined
package lsu_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [1:0] MEM_B = 2'd0;
  localparam logic [1:0] MEM_H = 2'd1;
  localparam logic [1:0] MEM_W = 2'd2;

  localparam logic MEM_LOAD  = 1'b1;
  localparam logic MEM_STORE = 1'b0;

  // Halves must be 2-byte aligned; words (codes 2 and 3) 4-byte aligned.
  function automatic logic is_misaligned(input logic [1:0] width, input logic [1:0] addr_lo);
    logic res;
    res = 1'b0;
    if (width == MEM_H)
      res = addr_lo[0];
    else if (width[1])
      res = (addr_lo != 2'b00);
    return res;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational lane logic for the load/store sequencer.
//   width_i   access width code      addr_lo_i  address bits [1:0]
//   rdtype_i  0 = sign, 1 = zero-extend loads
//   wdata_i   raw store data          rdata_i    bus read word
//   be_o      byte enables            wdata_o    lane-replicated store data
//   ldata_o   extracted/extended load data
// Lane selection assumes a 32-bit data bus (XLEN = 32).
module lsu_align
  import lsu_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]      width_i,
  input  logic [1:0]      addr_lo_i,
  input  logic            rdtype_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [3:0]      be_o,
  output logic [XLEN-1:0] wdata_o,
  output logic [XLEN-1:0] ldata_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    case (addr_lo_i)
      2'd0:    byte_lane = rdata_i[7:0];
      2'd1:    byte_lane = rdata_i[15:8];
      2'd2:    byte_lane = rdata_i[23:16];
      default: byte_lane = rdata_i[31:24];
    endcase
    half_lane = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  always_comb begin
    be_o    = 4'b1111;
    wdata_o = wdata_i;
    ldata_o = rdata_i;
    case (width_i)
      MEM_B: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {(XLEN/8){wdata_i[7:0]}};
        ldata_o = {{(XLEN-8){~rdtype_i & byte_lane[7]}}, byte_lane};
      end
      MEM_H: begin
        be_o    = 4'b0011 << {addr_lo_i[1], 1'b0};
        wdata_o = {(XLEN/16){wdata_i[15:0]}};
        ldata_o = {{(XLEN-16){~rdtype_i & half_lane[15]}}, half_lane};
      end
      default: ;  // word: defaults above, rdtype ignored
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store sequencer between execute and the data-memory bus.
// Runs one req/ack transaction per memory instruction, stalls execute while
// the access is outstanding and aborts it after TIMEOUT BUSY cycles.
// Ports:
//   clk, rst_n (async, active-low)
//   ex_*_i       execute-stage memory decode, address and store data
//   stall_o      hold execute stage
//   bus_*_o/_i   req/ack data-memory bus
//   wb_valid_o/wb_data_o  load result pulse and registered data
//   err_o, misalign_o     abort / misalignment pulses
// Optional feature: define LSU_MISALIGN_CHK_EN to trap misaligned halves and
// words instead of silently aligning them down.
module lsu_ctrl
  import lsu_ctrl_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid_i,
  input  logic            ex_mtype_i,
  input  logic            ex_mem_rw_i,
  input  logic [1:0]      ex_mem_width_i,
  input  logic            ex_mem_rdtype_i,
  input  logic [XLEN-1:0] ex_addr_i,
  input  logic [XLEN-1:0] ex_wdata_i,
  output logic            stall_o,
  output logic            bus_req_o,
  output logic            bus_we_o,
  output logic [XLEN-1:0] bus_addr_o,
  output logic [3:0]      bus_be_o,
  output logic [XLEN-1:0] bus_wdata_o,
  input  logic            bus_ack_i,
  input  logic [XLEN-1:0] bus_rdata_i,
  output logic            wb_valid_o,
  output logic [XLEN-1:0] wb_data_o,
  output logic            err_o,
  output logic            misalign_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t          state_reg;
  logic            rw_reg;
  logic [1:0]      width_reg;
  logic            rdtype_reg;
  logic [1:0]      addr_lo_reg;
  logic            bus_req_reg;
  logic            bus_we_reg;
  logic [XLEN-1:0] bus_addr_reg;
  logic [3:0]      bus_be_reg;
  logic [XLEN-1:0] bus_wdata_reg;
  logic            wb_valid_reg;
  logic [XLEN-1:0] wb_data_reg;
  logic            err_reg;
  logic            misalign_reg;
  logic [CNT_W-1:0] tmo_cnt_reg;

  logic            accept;
  logic            misalign_det;
  logic [1:0]      addr_lo_acc;
  logic [1:0]      align_width;
  logic [1:0]      align_addr_lo;
  logic            align_rdtype;
  logic [3:0]      align_be;
  logic [XLEN-1:0] align_wdata;
  logic [XLEN-1:0] align_ldata;

  assign accept = (state_reg == ST_IDLE) & ex_valid_i & ex_mtype_i;

`ifdef LSU_MISALIGN_CHK_EN
  assign misalign_det = is_misaligned(ex_mem_width_i, ex_addr_i[1:0]);
  assign addr_lo_acc  = ex_addr_i[1:0];
`else
  // Without the trap, offending low bits are dropped and the access proceeds.
  assign misalign_det = 1'b0;
  always_comb begin
    addr_lo_acc = ex_addr_i[1:0];
    if (ex_mem_width_i[1])
      addr_lo_acc = 2'b00;
    else if (ex_mem_width_i == MEM_H)
      addr_lo_acc = {ex_addr_i[1], 1'b0};
  end
`endif

  // One lane unit serves both directions: in IDLE it shapes the incoming
  // store, in BUSY it extracts the load from the latched access attributes.
  always_comb begin
    if (state_reg == ST_IDLE) begin
      align_width   = ex_mem_width_i;
      align_addr_lo = addr_lo_acc;
      align_rdtype  = ex_mem_rdtype_i;
    end else begin
      align_width   = width_reg;
      align_addr_lo = addr_lo_reg;
      align_rdtype  = rdtype_reg;
    end
  end

  lsu_align #(.XLEN(XLEN)) u_align (
    .width_i   (align_width),
    .addr_lo_i (align_addr_lo),
    .rdtype_i  (align_rdtype),
    .wdata_i   (ex_wdata_i),
    .rdata_i   (bus_rdata_i),
    .be_o      (align_be),
    .wdata_o   (align_wdata),
    .ldata_o   (align_ldata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      rw_reg        <= 1'b0;
      width_reg     <= 2'b00;
      rdtype_reg    <= 1'b0;
      addr_lo_reg   <= 2'b00;
      bus_req_reg   <= 1'b0;
      bus_we_reg    <= 1'b0;
      bus_addr_reg  <= '0;
      bus_be_reg    <= 4'b0000;
      bus_wdata_reg <= '0;
      wb_valid_reg  <= 1'b0;
      wb_data_reg   <= '0;
      err_reg       <= 1'b0;
      misalign_reg  <= 1'b0;
      tmo_cnt_reg   <= '0;
    end else begin
      // DONE pulses are set on the transition into DONE and last one cycle.
      wb_valid_reg <= 1'b0;
      err_reg      <= 1'b0;
      misalign_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            rw_reg        <= ex_mem_rw_i;
            width_reg     <= ex_mem_width_i;
            rdtype_reg    <= ex_mem_rdtype_i;
            addr_lo_reg   <= addr_lo_acc;
            bus_we_reg    <= (ex_mem_rw_i == MEM_STORE);
            bus_addr_reg  <= {ex_addr_i[XLEN-1:2], 2'b00};
            bus_be_reg    <= align_be;
            bus_wdata_reg <= align_wdata;
            tmo_cnt_reg   <= '0;
            if (misalign_det) begin
              state_reg    <= ST_DONE;
              err_reg      <= 1'b1;
              misalign_reg <= 1'b1;
            end else begin
              state_reg   <= ST_BUSY;
              bus_req_reg <= 1'b1;
            end
          end
        end
        ST_BUSY: begin
          if (bus_ack_i) begin
            bus_req_reg <= 1'b0;
            state_reg   <= ST_DONE;
            if (rw_reg == MEM_LOAD) begin
              wb_data_reg  <= align_ldata;
              wb_valid_reg <= 1'b1;
            end
          end else if (tmo_cnt_reg == CNT_LAST) begin
            // This is the TIMEOUT-th BUSY cycle without ack.
            bus_req_reg <= 1'b0;
            state_reg   <= ST_DONE;
            err_reg     <= 1'b1;
          end else begin
            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
          end
        end
        ST_DONE: state_reg <= ST_IDLE;
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // Stall is combinational so the accept cycle itself holds execute.
  assign stall_o     = accept | (state_reg == ST_BUSY);
  assign bus_req_o   = bus_req_reg;
  assign bus_we_o    = bus_we_reg;
  assign bus_addr_o  = bus_addr_reg;
  assign bus_be_o    = bus_be_reg;
  assign bus_wdata_o = bus_wdata_reg;
  assign wb_valid_o  = wb_valid_reg;
  assign wb_data_o   = wb_data_reg;
  assign err_o       = err_reg;
  assign misalign_o  = misalign_reg;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed self-checking bench for lsu_ctrl (TIMEOUT = 16).
module tb_lsu_ctrl;

  localparam int XLEN    = 32;
  localparam int TIMEOUT = 16;

  logic            clk;
  logic            rst_n;
  logic            ex_valid;
  logic            ex_mtype;
  logic            ex_rw;
  logic [1:0]      ex_width;
  logic            ex_rdtype;
  logic [XLEN-1:0] ex_addr;
  logic [XLEN-1:0] ex_wdata;
  logic            stall_o;
  logic            bus_req_o;
  logic            bus_we_o;
  logic [XLEN-1:0] bus_addr_o;
  logic [3:0]      bus_be_o;
  logic [XLEN-1:0] bus_wdata_o;
  logic            bus_ack;
  logic [XLEN-1:0] bus_rdata;
  logic            wb_valid_o;
  logic [XLEN-1:0] wb_data_o;
  logic            err_o;
  logic            misalign_o;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  lsu_ctrl #(.XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .ex_valid_i      (ex_valid),
    .ex_mtype_i      (ex_mtype),
    .ex_mem_rw_i     (ex_rw),
    .ex_mem_width_i  (ex_width),
    .ex_mem_rdtype_i (ex_rdtype),
    .ex_addr_i       (ex_addr),
    .ex_wdata_i      (ex_wdata),
    .stall_o         (stall_o),
    .bus_req_o       (bus_req_o),
    .bus_we_o        (bus_we_o),
    .bus_addr_o      (bus_addr_o),
    .bus_be_o        (bus_be_o),
    .bus_wdata_o     (bus_wdata_o),
    .bus_ack_i       (bus_ack),
    .bus_rdata_i     (bus_rdata),
    .wb_valid_o      (wb_valid_o),
    .wb_data_o       (wb_data_o),
    .err_o           (err_o),
    .misalign_o      (misalign_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic rw, input logic [1:0] w, input logic rdt,
                          input logic [31:0] a, input logic [31:0] wd);
    ex_valid  = 1'b1;
    ex_mtype  = 1'b1;
    ex_rw     = rw;
    ex_width  = w;
    ex_rdtype = rdt;
    ex_addr   = a;
    ex_wdata  = wd;
  endtask

  task automatic clear_op();
    ex_valid  = 1'b0;
    ex_mtype  = 1'b0;
    ex_rw     = 1'b0;
    ex_width  = 2'd0;
    ex_rdtype = 1'b0;
    ex_addr   = '0;
    ex_wdata  = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_op();
    bus_ack = 1'b0;
    bus_rdata = '0;
    repeat (2) tick();
    vec_cnt++;
    if ({stall_o, bus_req_o, bus_we_o, bus_be_o, wb_valid_o, err_o, misalign_o} !== 10'b0) begin
      $display("FAIL reset_ctrl: got %b expected 0", {stall_o, bus_req_o, bus_we_o, bus_be_o, wb_valid_o, err_o, misalign_o});
      miss_cnt++;
    end
    vec_cnt++;
    if ({bus_addr_o, bus_wdata_o, wb_data_o} !== 96'b0) begin
      $display("FAIL reset_data: addr=%h wdata=%h wb=%h expected 0", bus_addr_o, bus_wdata_o, wb_data_o);
      miss_cnt++;
    end
    rst_n = 1'b1;
    tick();
    // Non-memory instruction: never stalled, never requests the bus.
    ex_valid = 1'b1;
    ex_mtype = 1'b0;
    #1;
    vec_cnt++;
    if (stall_o !== 1'b0) begin
      $display("FAIL nonmem_stall: got %b expected 0", stall_o);
      miss_cnt++;
    end
    tick();
    clear_op();
    vec_cnt++;
    if (bus_req_o !== 1'b0) begin
      $display("FAIL nonmem_req: got %b expected 0", bus_req_o);
      miss_cnt++;
    end
    $display("txn reset/non-mem done");
  endtask

  task automatic test_lb();
    drive_op(1'b1, 2'd0, 1'b0, 32'h0000_0103, 32'h0);
    #1;
    vec_cnt++;
    if (stall_o !== 1'b1) begin
      $display("FAIL lb_stall_T: got %b expected 1", stall_o);
      miss_cnt++;
    end
    tick();
    clear_op();
    vec_cnt++;
    if ({bus_req_o, bus_we_o, bus_be_o} !== 6'b10_1000 || bus_addr_o !== 32'h0000_0100) begin
      $display("FAIL lb_bus: req=%b we=%b be=%b addr=%h expected req=1 we=0 be=1000 addr=00000100",
               bus_req_o, bus_we_o, bus_be_o, bus_addr_o);
      miss_cnt++;
    end
    bus_ack = 1'b1;
    bus_rdata = 32'h80FF_FF00;
    tick();
    bus_ack = 1'b0;
    vec_cnt++;
    if (wb_valid_o !== 1'b1 || wb_data_o !== 32'hFFFF_FF80 || stall_o !== 1'b0 || err_o !== 1'b0) begin
      $display("FAIL lb_done: valid=%b data=%h stall=%b err=%b expected valid=1 data=ffffff80 stall=0 err=0",
               wb_valid_o, wb_data_o, stall_o, err_o);
      miss_cnt++;
    end
    tick();
    vec_cnt++;
    if (wb_valid_o !== 1'b0 || wb_data_o !== 32'hFFFF_FF80) begin
      $display("FAIL lb_hold: valid=%b data=%h expected valid=0 data=ffffff80", wb_valid_o, wb_data_o);
      miss_cnt++;
    end
    $display("txn LB addr=00000103 wb=%h", wb_data_o);
  endtask

  task automatic test_lhu_wait();
    int stall_cnt;
    stall_cnt = 0;
    drive_op(1'b1, 2'd1, 1'b1, 32'h0000_0202, 32'h0);
    #1;
    if (stall_o) stall_cnt++;
    tick();
    clear_op();
    vec_cnt++;
    if (bus_be_o !== 4'b1100 || bus_addr_o !== 32'h0000_0200) begin
      $display("FAIL lhu_bus: be=%b addr=%h expected be=1100 addr=00000200", bus_be_o, bus_addr_o);
      miss_cnt++;
    end
    for (int i = 0; i < 3; i++) begin
      if (stall_o) stall_cnt++;
      tick();
    end
    bus_ack = 1'b1;
    bus_rdata = 32'h8001_1234;
    if (stall_o) stall_cnt++;
    tick();
    bus_ack = 1'b0;
    vec_cnt++;
    if (wb_valid_o !== 1'b1 || wb_data_o !== 32'h0000_8001 || stall_o !== 1'b0) begin
      $display("FAIL lhu_done: valid=%b data=%h stall=%b expected valid=1 data=00008001 stall=0",
               wb_valid_o, wb_data_o, stall_o);
      miss_cnt++;
    end
    vec_cnt++;
    if (stall_cnt !== 5) begin
      $display("FAIL lhu_stall_cycles: got %0d expected 5", stall_cnt);
      miss_cnt++;
    end
    tick();
    $display("txn LHU addr=00000202 wb=%h stall_cycles=%0d", wb_data_o, stall_cnt);
  endtask

  task automatic test_sb();
    drive_op(1'b0, 2'd0, 1'b0, 32'h0000_0001, 32'h0000_00AB);
    #1;
    tick();
    clear_op();
    vec_cnt++;
    if ({bus_req_o, bus_we_o, bus_be_o} !== 6'b11_0010 || bus_wdata_o !== 32'hABAB_ABAB ||
        bus_addr_o !== 32'h0) begin
      $display("FAIL sb_bus: req=%b we=%b be=%b wdata=%h addr=%h expected 1 1 0010 abababab 00000000",
               bus_req_o, bus_we_o, bus_be_o, bus_wdata_o, bus_addr_o);
      miss_cnt++;
    end
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    vec_cnt++;
    if (wb_valid_o !== 1'b0 || err_o !== 1'b0 || bus_req_o !== 1'b0) begin
      $display("FAIL sb_done: valid=%b err=%b req=%b expected 0 0 0", wb_valid_o, err_o, bus_req_o);
      miss_cnt++;
    end
    tick();
    $display("txn SB addr=00000001 wdata=abababab");
  endtask

  task automatic do_lw(input logic [31:0] a, input logic [31:0] rd, input string tag);
    drive_op(1'b1, 2'd2, 1'b0, a, 32'h0);
    #1;
    tick();
    clear_op();
    vec_cnt++;
    if (bus_req_o !== 1'b1 || bus_be_o !== 4'b1111) begin
      $display("FAIL %s_req: req=%b be=%b expected req=1 be=1111", tag, bus_req_o, bus_be_o);
      miss_cnt++;
    end
    bus_ack = 1'b1;
    bus_rdata = rd;
    tick();
    bus_ack = 1'b0;
    vec_cnt++;
    if (wb_valid_o !== 1'b1 || wb_data_o !== rd || err_o !== 1'b0) begin
      $display("FAIL %s_done: valid=%b data=%h err=%b expected valid=1 data=%h err=0",
               tag, wb_valid_o, wb_data_o, err_o, rd);
      miss_cnt++;
    end
    tick();
    $display("txn LW %s addr=%h wb=%h", tag, a, wb_data_o);
  endtask

  task automatic test_timeout();
    int req_cnt;
    req_cnt = 0;
    drive_op(1'b0, 2'd2, 1'b0, 32'h0000_0300, 32'hDEAD_BEEF);
    #1;
    tick();
    clear_op();
    for (int i = 0; i < 40 && bus_req_o; i++) begin
      req_cnt++;
      tick();
    end
    vec_cnt++;
    if (bus_req_o !== 1'b0) begin
      $display("FAIL tmo_bound: req still %b after 40 cycles expected 0", bus_req_o);
      miss_cnt++;
    end
    vec_cnt++;
    if (req_cnt !== TIMEOUT) begin
      $display("FAIL tmo_req_cycles: got %0d expected %0d", req_cnt, TIMEOUT);
      miss_cnt++;
    end
    vec_cnt++;
    if (err_o !== 1'b1 || wb_valid_o !== 1'b0 || misalign_o !== 1'b0) begin
      $display("FAIL tmo_done: err=%b valid=%b misalign=%b expected 1 0 0", err_o, wb_valid_o, misalign_o);
      miss_cnt++;
    end
    tick();
    vec_cnt++;
    if (err_o !== 1'b0) begin
      $display("FAIL tmo_pulse: err=%b expected 0", err_o);
      miss_cnt++;
    end
    $display("txn SW timeout req_cycles=%0d", req_cnt);
    do_lw(32'h0000_0400, 32'hCAFE_F00D, "after_tmo");
  endtask

  task automatic test_lw_misalign();
    drive_op(1'b1, 2'd2, 1'b0, 32'h0000_0102, 32'h0);
    #1;
    vec_cnt++;
    if (stall_o !== 1'b1) begin
      $display("FAIL mis_stall_T: got %b expected 1", stall_o);
      miss_cnt++;
    end
    tick();
    clear_op();
`ifdef LSU_MISALIGN_CHK_EN
    vec_cnt++;
    if ({bus_req_o, misalign_o, err_o, wb_valid_o, stall_o} !== 5'b01100) begin
      $display("FAIL mis_trap: req/mis/err/valid/stall=%b expected 01100",
               {bus_req_o, misalign_o, err_o, wb_valid_o, stall_o});
      miss_cnt++;
    end
    tick();
    vec_cnt++;
    if (misalign_o !== 1'b0 || err_o !== 1'b0) begin
      $display("FAIL mis_pulse: mis=%b err=%b expected 0 0", misalign_o, err_o);
      miss_cnt++;
    end
`else
    vec_cnt++;
    if (bus_req_o !== 1'b1 || bus_addr_o !== 32'h0000_0100 || bus_be_o !== 4'b1111 || misalign_o !== 1'b0) begin
      $display("FAIL mis_align: req=%b addr=%h be=%b mis=%b expected 1 00000100 1111 0",
               bus_req_o, bus_addr_o, bus_be_o, misalign_o);
      miss_cnt++;
    end
    bus_ack = 1'b1;
    bus_rdata = 32'h1122_3344;
    tick();
    bus_ack = 1'b0;
    vec_cnt++;
    if (wb_valid_o !== 1'b1 || wb_data_o !== 32'h1122_3344 || misalign_o !== 1'b0) begin
      $display("FAIL mis_done: valid=%b data=%h mis=%b expected 1 11223344 0", wb_valid_o, wb_data_o, misalign_o);
      miss_cnt++;
    end
    tick();
`endif
    $display("txn LW misaligned addr=00000102");
  endtask

  task automatic test_reset_busy();
    drive_op(1'b1, 2'd2, 1'b0, 32'h0000_0500, 32'h0);
    #1;
    tick();
    clear_op();
    vec_cnt++;
    if (bus_req_o !== 1'b1) begin
      $display("FAIL rstb_req_pre: got %b expected 1", bus_req_o);
      miss_cnt++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    vec_cnt++;
    if (bus_req_o !== 1'b0 || stall_o !== 1'b0) begin
      $display("FAIL rstb_async: req=%b stall=%b expected 0 0", bus_req_o, stall_o);
      miss_cnt++;
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    vec_cnt++;
    if (wb_valid_o !== 1'b0 || err_o !== 1'b0 || bus_req_o !== 1'b0) begin
      $display("FAIL rstb_nopulse: valid=%b err=%b req=%b expected 0 0 0", wb_valid_o, err_o, bus_req_o);
      miss_cnt++;
    end
    $display("txn reset during BUSY");
    do_lw(32'h0000_0600, 32'h0F0F_0F0F, "after_rst");
  endtask

  initial begin
    test_reset();
    test_lb();
    test_lhu_wait();
    test_sb();
    test_timeout();
    test_lw_misalign();
    test_reset_busy();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
